// File: rtl/fixed_point_pkg.sv
// Shared fixed-point widths and the MAC control-state encoding.
// Widths derive from the default Q7.9 operand format.
package fixed_point_pkg;

  localparam int DEF_INT_BITS  = 7;
  localparam int DEF_FRAC_BITS = 9;
  localparam int OPERAND_W     = DEF_INT_BITS + DEF_FRAC_BITS;
  localparam int WIDE_W        = 2 * OPERAND_W;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/sat_add_wide.sv
// Two's-complement adder that clamps to the representable range instead of
// wrapping, and flags when clamping happened.
module sat_add_wide #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             overflow_o
);

  logic [WIDTH-1:0] raw_sum;

  assign raw_sum = a_i + b_i;

  // Overflow only when both operands share a sign that the raw sum lost.
  assign overflow_o = (a_i[WIDTH-1] == b_i[WIDTH-1]) &&
                      (raw_sum[WIDTH-1] != a_i[WIDTH-1]);

  always_comb begin
    sum_o = raw_sum;
    if (overflow_o) begin
      sum_o = a_i[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                           : {1'b0, {(WIDTH-1){1'b1}}};
    end
  end

endmodule

// File: rtl/mac_accumulator.sv
// Two-stage signed multiply-accumulate over a fixed-length vector with
// saturating wide accumulation and a valid/ready result handshake.
module mac_accumulator
  import fixed_point_pkg::*;
#(
  parameter int para_int_bits  = DEF_INT_BITS,
  parameter int para_frac_bits = DEF_FRAC_BITS,
  parameter int VEC_LEN        = 16
) (
  input  logic                                         clk,
  input  logic                                         rst_n,
  input  logic [para_int_bits+para_frac_bits-1:0]      a_i,
  input  logic [para_int_bits+para_frac_bits-1:0]      b_i,
  input  logic                                         in_valid,
  output logic                                         in_ready,
  output logic [2*(para_int_bits+para_frac_bits)-1:0]  acc_o,
  output logic                                         out_valid,
  input  logic                                         out_ready,
  output logic                                         sat_o
);

  localparam int W     = para_int_bits + para_frac_bits;
  localparam int W2    = 2 * W;
  localparam int CNT_W = $clog2(VEC_LEN);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(VEC_LEN - 1);

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic signed [W2-1:0] prod_q;
  logic signed [W2-1:0] prod_d;
  logic               prod_vld_q;
  logic [W2-1:0]      acc_q;
  logic               sat_q;
  logic               out_valid_q;

  logic signed [W2-1:0] a_ext;
  logic signed [W2-1:0] b_ext;
  logic [W2-1:0]      sum_d;
  logic               ovf_d;
  logic               accept;

  assign in_ready = (state_q == ST_RUN);
  assign accept   = in_valid && in_ready;

  // Sign-extend before multiplying so the full 2W-bit product is kept.
  assign a_ext  = {{W{a_i[W-1]}}, a_i};
  assign b_ext  = {{W{b_i[W-1]}}, b_i};
  assign prod_d = a_ext * b_ext;

  sat_add_wide #(
    .WIDTH (W2)
  ) u_sat_add (
    .a_i        (acc_q),
    .b_i        (prod_q),
    .sum_o      (sum_d),
    .overflow_o (ovf_d)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_RUN;
      cnt_q       <= '0;
      prod_q      <= '0;
      prod_vld_q  <= 1'b0;
      acc_q       <= '0;
      sat_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      prod_vld_q <= accept;
      if (accept) begin
        prod_q <= prod_d;
      end

      if (prod_vld_q) begin
        acc_q <= sum_d;
        if (ovf_d) begin
          sat_q <= 1'b1;
        end
      end

      case (state_q)
        ST_RUN: begin
          if (accept) begin
            if (cnt_q == LAST_CNT) begin
              cnt_q   <= '0;
              state_q <= ST_DRAIN;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        ST_DRAIN: begin
          state_q     <= ST_DONE;
          out_valid_q <= 1'b1;
        end
        ST_DONE: begin
          // Handshake starts a fresh vector from a clean accumulator.
          if (out_ready) begin
            state_q     <= ST_RUN;
            out_valid_q <= 1'b0;
            acc_q       <= '0;
            sat_q       <= 1'b0;
            cnt_q       <= '0;
            prod_vld_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_RUN;
        end
      endcase
    end
  end

  assign acc_o     = acc_q;
  assign sat_o     = sat_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_mac_accumulator.sv
// Directed vector bench for mac_accumulator with VEC_LEN=4: table-driven dot
// products plus hand-written backpressure, gap and reset sequences.
module tb_mac_accumulator;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] a_i;
  logic [15:0] b_i;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] acc_o;
  logic        out_valid;
  logic        out_ready;
  logic        sat_o;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct packed {
    logic [3:0][15:0] a;
    logic [3:0][15:0] b;
    logic [31:0]      acc;
    logic             sat;
  } vec_t;

  vec_t tbl [4];

  mac_accumulator #(
    .para_int_bits  (7),
    .para_frac_bits (9),
    .VEC_LEN        (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a_i       (a_i),
    .b_i       (b_i),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .acc_o     (acc_o),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sat_o     (sat_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%08h), expected %0d (0x%08h)", name, act, act, exp, exp);
  endtask

  function automatic vec_t make_vec(input int a0, input int b0, input int a1, input int b1,
                                    input int a2, input int b2, input int a3, input int b3,
                                    input logic [31:0] acc, input logic sat);
    vec_t v;
    v.a[0] = 16'(a0); v.b[0] = 16'(b0);
    v.a[1] = 16'(a1); v.b[1] = 16'(b1);
    v.a[2] = 16'(a2); v.b[2] = 16'(b2);
    v.a[3] = 16'(a3); v.b[3] = 16'(b3);
    v.acc  = acc;
    v.sat  = sat;
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Feed one pair and wait (bounded) until it is accepted.
  task automatic feed_pair(input logic [15:0] a, input logic [15:0] b);
    int t;
    a_i = a; b_i = b; in_valid = 1'b1;
    t = 0;
    while (!in_ready && t < 20) begin
      step();
      t++;
    end
    if (t == 20) check("in_ready_timeout", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input int id, input bit gaps, input int hold);
    int lat;
    for (int i = 0; i < 4; i++) begin
      if (gaps) repeat ($urandom_range(0, 3)) step();
      feed_pair(v.a[i], v.b[i]);
    end
    lat = 1;
    while (!out_valid && lat < 10) begin
      step();
      lat++;
    end
    check("latency", 32'(lat), 32'd2);
    check("acc", acc_o, v.acc);
    check("sat", 32'(sat_o), 32'(v.sat));
    check("in_ready_done", 32'(in_ready), 32'd0);
    $display("vector %0d: acc_o=%0d sat_o=%0d latency=%0d", id, $signed(acc_o), sat_o, lat);
    // Offer a pair during DONE; it must not be taken.
    for (int h = 0; h < hold; h++) begin
      a_i = 16'd512; b_i = 16'd512; in_valid = 1'b1;
      step();
      check("hold_acc", acc_o, v.acc);
      check("hold_in_ready", 32'(in_ready), 32'd0);
      check("hold_out_valid", 32'(out_valid), 32'd1);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("post_hs_out_valid", 32'(out_valid), 32'd0);
    check("post_hs_in_ready", 32'(in_ready), 32'd1);
  endtask

  initial begin
    tbl[0] = make_vec(512, 512, 512, 512, 512, 512, 512, 512, 32'd1048576, 1'b0);
    tbl[1] = make_vec(512, -512, 1024, 256, -256, -256, 0, 32767, 32'd65536, 1'b0);
    tbl[2] = make_vec(-32768, -32768, -32768, -32768, -32768, -32768, -32768, -32768,
                      32'h7FFF_FFFF, 1'b1);
    tbl[3] = make_vec(-32768, 32767, -32768, 32767, -32768, 32767, -32768, 32767,
                      32'h8000_0000, 1'b1);

    rst_n = 1'b0; a_i = '0; b_i = '0; in_valid = 1'b0; out_ready = 1'b0;
    #12;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_acc", acc_o, 32'd0);
    check("rst_sat", 32'(sat_o), 32'd0);
    step();
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 4; i++) run_vec(tbl[i], i, 1'b0, 0);

    // Random input gaps must give the gap-free result.
    run_vec(tbl[0], 10, 1'b1, 0);

    // Backpressure in DONE, then a vector that must not include the old sum.
    run_vec(tbl[0], 11, 1'b0, 5);
    run_vec(tbl[1], 12, 1'b0, 0);

    // Reset after two pairs discards the partial vector.
    feed_pair(16'd512, 16'd512);
    feed_pair(16'd512, 16'd512);
    rst_n = 1'b0;
    #2;
    check("midrst_acc", acc_o, 32'd0);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    step();
    rst_n = 1'b1;
    step();
    run_vec(tbl[0], 13, 1'b0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
